// File: rtl/video_scale_burst_writer.sv
// Buffers the scaled pixel stream in an FWFT FIFO and emits per-line write
// bursts (at most BURST_LEN pixels, 4 bytes per pixel) to the frame-buffer controller.
module video_scale_burst_writer #(
  parameter int unsigned iPIXEL_DEPTH = 8,
  parameter int unsigned iPIXEL_COLOR = 3,
  parameter int unsigned FIFO_DEPTH   = 1024,
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                                 vin_clk,
  input  logic                                 rst,
  input  logic                                 frame_sync,
  input  logic [iPIXEL_DEPTH*iPIXEL_COLOR-1:0] vin_dat,
  input  logic                                 vin_valid,
  output logic                                 vin_ready,
  input  logic [15:0]                          vout_xres,
  input  logic [15:0]                          vout_yres,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH-1:0]                line_stride,
  output logic                                 wr_req,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [15:0]                          wr_len,
  input  logic                                 wr_ack,
  input  logic                                 wr_dat_req,
  output logic [31:0]                          wr_dat,
  output logic                                 frame_done,
  output logic                                 proto_err
);
  localparam int unsigned PW    = iPIXEL_DEPTH * iPIXEL_COLOR;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_n;

  logic [PW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, flush;

  logic [15:0]           xres, yres;
  logic [ADDR_WIDTH-1:0] base, stride;

  logic [15:0]           out_x, out_x_n, out_y, out_y_n;
  logic [15:0]           remaining, remaining_n, wr_len_n, span, len, x_end;
  logic [ADDR_WIDTH-1:0] line_addr, line_addr_n, wr_addr_n;
  logic                  wr_req_n, frame_done_n;

  assign flush     = rst | frame_sync;
  assign vin_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push      = vin_valid & vin_ready;
  assign pop       = wr_dat_req & (state == DATA) & (count != '0);
  assign wr_dat    = (count == '0) ? '0 : 32'(mem[rptr]);

  always_ff @(posedge vin_clk) begin
    if (push) mem[wptr] <= vin_dat;
  end

  always_ff @(posedge vin_clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge vin_clk) begin
    if (rst) begin
      xres   <= '0;
      yres   <= '0;
      base   <= '0;
      stride <= '0;
    end else if (frame_sync) begin
      xres   <= vout_xres;
      yres   <= vout_yres;
      base   <= base_addr;
      stride <= line_stride;
    end
  end

  // out_x never exceeds xres, so the subtraction cannot underflow
  assign span = xres - out_x;
  assign len  = (32'(span) > BURST_LEN) ? 16'(BURST_LEN) : span;

  always_comb begin
    state_n      = state;
    wr_req_n     = wr_req;
    wr_addr_n    = wr_addr;
    wr_len_n     = wr_len;
    remaining_n  = remaining;
    out_x_n      = out_x;
    out_y_n      = out_y;
    line_addr_n  = line_addr;
    frame_done_n = 1'b0;
    x_end        = out_x + wr_len;
    unique case (state)
      IDLE: begin
        if (xres != '0 && yres != '0 && out_y < yres && 32'(count) >= 32'(len)) begin
          wr_addr_n = line_addr + ADDR_WIDTH'({out_x, 2'b00});
          wr_len_n  = len;
          wr_req_n  = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          wr_req_n    = 1'b0;
          remaining_n = wr_len;
          state_n     = DATA;
        end
      end
      DATA: begin
        if (pop) begin
          remaining_n = remaining - 16'd1;
          if (remaining == 16'd1) begin
            state_n = IDLE;
            if (x_end == xres) begin
              out_x_n      = '0;
              out_y_n      = out_y + 16'd1;
              line_addr_n  = line_addr + stride;
              frame_done_n = (out_y + 16'd1 == yres);
            end else begin
              out_x_n = x_end;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge vin_clk) begin
    if (flush) begin
      state      <= IDLE;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_len     <= '0;
      remaining  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
      line_addr  <= rst ? '0 : base_addr;
    end else begin
      state      <= state_n;
      wr_req     <= wr_req_n;
      wr_addr    <= wr_addr_n;
      wr_len     <= wr_len_n;
      remaining  <= remaining_n;
      out_x      <= out_x_n;
      out_y      <= out_y_n;
      frame_done <= frame_done_n;
      line_addr  <= line_addr_n;
    end
  end

  always_ff @(posedge vin_clk) begin
    if (rst)                                proto_err <= 1'b0;
    else if (wr_dat_req && state != DATA)   proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_video_scale_burst_writer.sv
// Randomized bench for video_scale_burst_writer: the bench plays upstream source
// and memory controller, checking against burst lists computed from frame geometry.
module tb_video_scale_burst_writer;
  localparam int FD = 16;
  localparam int BL = 8;
  localparam int AW = 32;

  logic        vin_clk = 1'b0, rst = 1'b1, frame_sync = 1'b0;
  logic [23:0] vin_dat = '0;
  logic        vin_valid = 1'b0, vin_ready;
  logic [15:0] vout_xres = '0, vout_yres = '0, wr_len;
  logic [31:0] base_addr = '0, line_stride = '0, wr_addr, wr_dat;
  logic        wr_req, wr_ack = 1'b0, wr_dat_req = 1'b0, frame_done, proto_err;

  int n_checks = 0, n_bad = 0;
  int occ = 0, fd_total = 0, req_total = 0;
  logic push_now = 1'b0, pop_now = 1'b0;
  logic [31:0] exp_pix[$];
  logic [31:0] exp_addr[$];
  int          exp_len[$];

  video_scale_burst_writer #(
    .iPIXEL_DEPTH(8), .iPIXEL_COLOR(3), .FIFO_DEPTH(FD), .BURST_LEN(BL), .ADDR_WIDTH(AW)
  ) dut (
    .vin_clk(vin_clk), .rst(rst), .frame_sync(frame_sync),
    .vin_dat(vin_dat), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vout_xres(vout_xres), .vout_yres(vout_yres),
    .base_addr(base_addr), .line_stride(line_stride),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .wr_dat_req(wr_dat_req), .wr_dat(wr_dat),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  always #5 vin_clk = ~vin_clk;

  // occupancy implied by the handshakes the bench itself performed
  always @(posedge vin_clk) begin
    if (rst || frame_sync) occ <= 0;
    else                   occ <= occ + int'(push_now) - int'(pop_now);
  end

  always @(negedge vin_clk) begin
    if (frame_done) fd_total <= fd_total + 1;
    if (wr_req)     req_total <= req_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] next_pix();
    if (exp_pix.size() == 0) return 32'hDEAD_BEEF;
    return exp_pix.pop_front();
  endfunction

  function automatic void build_bursts(input int xr, input int yr,
                                       input logic [31:0] base, input logic [31:0] stride);
    exp_addr.delete();
    exp_len.delete();
    for (int y = 0; y < yr; y++)
      for (int x = 0; x < xr; x += BL) begin
        exp_addr.push_back(base + 32'(y) * stride + 32'(x) * 32'd4);
        exp_len.push_back((xr - x < BL) ? xr - x : BL);
      end
  endfunction

  task automatic do_sync(input int xr, input int yr, input logic [31:0] base, input logic [31:0] stride);
    wr_dat_req = 1'b0; pop_now = 1'b0; wr_ack = 1'b0;
    vin_valid = 1'b0; push_now = 1'b0;
    vout_xres = 16'(xr); vout_yres = 16'(yr);
    base_addr = base; line_stride = stride;
    frame_sync = 1'b1;
    exp_pix.delete();
    @(negedge vin_clk);
    frame_sync = 1'b0;
  endtask

  task automatic produce(input int n, input bit gaps);
    int sent = 0, cyc = 0;
    logic [23:0] d;
    logic held = 1'b0;
    d = 24'($urandom);
    while (sent < n && cyc < 3000) begin
      @(negedge vin_clk);
      cyc++;
      push_now = 1'b0;
      check_eq("vin_ready", 32'(vin_ready), 32'(occ < FD));
      if (held || !gaps || $urandom_range(2) != 0) begin
        vin_valid = 1'b1;
        vin_dat   = d;
        if (vin_ready) begin
          push_now = 1'b1;
          exp_pix.push_back({8'h00, d});
          sent++;
          d = 24'($urandom);
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else begin
        vin_valid = 1'b0;
      end
    end
    @(negedge vin_clk);
    vin_valid = 1'b0;
    push_now  = 1'b0;
    check_eq("produce_count", 32'(sent), 32'(n));
  endtask

  task automatic serve(input int nb, input int hold);
    logic [31:0] ea;
    int el, w;
    for (int b = 0; b < nb; b++) begin
      w = 0;
      while (!wr_req && w < 3000) begin @(negedge vin_clk); w++; end
      if (!wr_req) begin
        check_eq("req_timeout", 32'(wr_req), 32'd1);
        return;
      end
      ea = exp_addr.pop_front();
      el = exp_len.pop_front();
      check_eq("wr_addr", wr_addr, ea);
      check_eq("wr_len", 32'(wr_len), 32'(el));
      repeat (hold) @(negedge vin_clk);
      if (hold > 0) begin
        check_eq("req_held", 32'(wr_req), 32'd1);
        check_eq("addr_held", wr_addr, ea);
      end
      if (b == 0 && hold > 20) check_eq("bp_full", 32'(vin_ready), 32'd0);
      wr_ack = 1'b1;
      @(negedge vin_clk);
      wr_ack = 1'b0;
      check_eq("req_drop", 32'(wr_req), 32'd0);
      for (int i = 0; i < el; i++) begin
        if ($urandom_range(3) == 0) begin
          wr_dat_req = 1'b0; pop_now = 1'b0;
          @(negedge vin_clk);
        end
        wr_dat_req = 1'b1; pop_now = 1'b1;
        check_eq("wr_dat", wr_dat, next_pix());
        @(negedge vin_clk);
      end
      wr_dat_req = 1'b0; pop_now = 1'b0;
      check_eq("frame_done", 32'(frame_done), 32'(b == nb - 1));
      check_eq("burst_gap", 32'(wr_req), 32'd0);
    end
  endtask

  task automatic frame_body(input int xr, input int yr, input logic [31:0] base,
                            input logic [31:0] stride, input int hold, input int extra);
    int nb, fd0;
    fd0 = fd_total;
    build_bursts(xr, yr, base, stride);
    nb = exp_addr.size();
    fork
      produce(xr * yr + extra, 1'b1);
      serve(nb, hold);
    join
    repeat (4) @(negedge vin_clk);
    check_eq("idle_after_frame", 32'(wr_req), 32'd0);
    check_eq("frame_done_count", 32'(fd_total - fd0), 32'd1);
    check_eq("proto_err_clear", 32'(proto_err), 32'd0);
  endtask

  task automatic run_frame(input int xr, input int yr, input logic [31:0] base,
                           input logic [31:0] stride, input int hold, input int extra);
    do_sync(xr, yr, base, stride);
    frame_body(xr, yr, base, stride, hold, extra);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r0;
    repeat (3) @(negedge vin_clk);
    rst = 1'b0;
    check_eq("rst_vin_ready", 32'(vin_ready), 32'd1);
    check_eq("rst_wr_req", 32'(wr_req), 32'd0);
    check_eq("rst_wr_addr", wr_addr, 32'd0);
    check_eq("rst_wr_len", 32'(wr_len), 32'd0);
    check_eq("rst_wr_dat", wr_dat, 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);

    run_frame(4, 2, 32'h1000, 32'h100, 1, 0);
    run_frame(20, 1, 32'h0, 32'h0, 2, 0);
    run_frame(20, 2, 32'h4000, 32'h200, 40, 2);
    run_frame(4, 2, 32'hFFFF_FF00, 32'h100, 0, 0);

    // frame_sync in the middle of a burst
    do_sync(16, 1, 32'h2000, 32'h0);
    build_bursts(16, 1, 32'h2000, 32'h0);
    produce(16, 1'b0);
    w = 0;
    while (!wr_req && w < 3000) begin @(negedge vin_clk); w++; end
    check_eq("mid_req", 32'(wr_req), 32'd1);
    check_eq("mid_addr", wr_addr, 32'h2000);
    wr_ack = 1'b1;
    @(negedge vin_clk);
    wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_dat_req = 1'b1; pop_now = 1'b1;
      check_eq("mid_dat", wr_dat, next_pix());
      @(negedge vin_clk);
    end
    do_sync(8, 1, 32'h3000, 32'h0);
    check_eq("sync_req_low", 32'(wr_req), 32'd0);
    check_eq("sync_fifo_empty", wr_dat, 32'd0);
    check_eq("sync_ready", 32'(vin_ready), 32'd1);
    frame_body(8, 1, 32'h3000, 32'h0, 1, 0);

    // zero width: input accepted, no requests; then a stray data pop
    do_sync(0, 2, 32'h100, 32'h40);
    r0 = req_total;
    produce(10, 1'b1);
    repeat (20) @(negedge vin_clk);
    check_eq("zero_no_req", 32'(req_total - r0), 32'd0);
    wr_dat_req = 1'b1;
    @(negedge vin_clk);
    wr_dat_req = 1'b0;
    check_eq("proto_set", 32'(proto_err), 32'd1);
    check_eq("idle_no_pop", wr_dat, exp_pix[0]);
    do_sync(4, 1, 32'h0, 32'h0);
    check_eq("proto_sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    @(negedge vin_clk);
    rst = 1'b0;
    check_eq("rst2_proto_err", 32'(proto_err), 32'd0);
    check_eq("rst2_wr_req", 32'(wr_req), 32'd0);
    check_eq("rst2_wr_dat", wr_dat, 32'd0);

    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 3)), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/video_scale_burst_writer.md
# video_scale_burst_writer

Downstream stage of the nearest-neighbour down-scaler. Takes the sparse scaled pixel stream (valid/ready), buffers it in a first-word-fall-through FIFO, and turns each output line into one or more fixed-maximum-length write bursts toward the frame-buffer memory controller. Each pixel occupies 4 bytes in memory. Line addresses are generated from a latched base address and line stride.

## Interface
- iPIXEL_DEPTH, 8, bits per colour component
- iPIXEL_COLOR, 3, colour components per pixel (iPIXEL_DEPTH*iPIXEL_COLOR ≤ 32)
- FIFO_DEPTH, 1024, pixel FIFO depth, power of two, ≥ BURST_LEN
- BURST_LEN, 64, maximum pixels per burst, ≥ 1
- ADDR_WIDTH, 32, byte address width

- vin_clk  in  1  single clock for the whole block
- rst  in  1  reset, synchronous and active-high
- frame_sync  in  1  frame start, active-high, sampled synchronously; clears and re-latches the block
- vin_dat  in  iPIXEL_DEPTH*iPIXEL_COLOR  scaled pixel
- vin_valid  in  1  vin_dat valid
- vin_ready  out  1  FIFO can accept a pixel
- vout_xres  in  16  scaled line width in pixels, latched on frame_sync
- vout_yres  in  16  scaled line count, latched on frame_sync
- base_addr  in  ADDR_WIDTH  frame byte address, latched on frame_sync
- line_stride  in  ADDR_WIDTH  bytes between line starts, latched on frame_sync
- wr_req  out  1  burst request
- wr_addr  out  ADDR_WIDTH  burst start byte address
- wr_len  out  16  burst length in pixels, 1..BURST_LEN
- wr_ack  in  1  one-cycle request acceptance
- wr_dat_req  in  1  controller pops one data word this cycle
- wr_dat  out  32  FIFO head pixel, zero-extended
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is popped
- proto_err  out  1  sticky: wr_dat_req seen outside DATA state

## Operation
- **Accept:** a pixel is written when vin_valid && vin_ready. vin_ready = (fifo_count < FIFO_DEPTH). Pixels offered while vin_ready=0 must be held by upstream; they are not dropped.
- **Latches:** xres, yres, base, and stride are latched on every cycle where frame_sync=1. Reset clears them to 0. While latched xres or yres is 0, no bursts are issued and input is still accepted.
- **Position tracking:** counters out_x (0..xres-1) and out_y (0..yres-1) track the next pixel to issue.
- **Line address:** a line_addr register starts at base. At each line end it adds stride. No multiplier is used. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- **State machine:**
  - IDLE:
    - Compute len = min(BURST_LEN, xres-out_x).
    - If xres≠0, yres≠0, out_y<yres and fifo_count ≥ len, register wr_addr = line_addr + (out_x<<2) and wr_len = len, assert wr_req, and go to REQ.
  - REQ:
    - Hold wr_req, wr_addr and wr_len stable until wr_ack=1.
    - On wr_ack, drop wr_req and go to DATA with remaining = wr_len.
  - DATA:
    - Each cycle with wr_dat_req=1 pops the FIFO head (wr_dat is valid combinationally from the head) and decrements remaining.
    - When the pop takes remaining from 1 to 0:
      - out_x += len.
      - If out_x reaches xres, set out_x=0, out_y++, and line_addr += stride.
      - Go to IDLE.
- **End of frame:** frame_done pulses on the cycle after the final pop where out_y reaches yres. After that, the block stays IDLE until the next frame_sync; excess input pixels accumulate in the FIFO.
- **Simultaneous read and write:** a push and a pop in the same cycle leave fifo_count unchanged.
- **Protocol error:** wr_dat_req outside DATA causes no pop and sets proto_err, which is cleared only by rst.
- **Reset and frame_sync:** either one, at any time including mid-burst, empties the FIFO, zeroes the counters, forces IDLE, and deasserts wr_req immediately (next edge). rst also clears the latches and proto_err; frame_sync re-latches instead. A partially transferred burst is abandoned.

## Timing
- **Reset values:**
  - vin_ready = 1 (combinational from an empty FIFO)
  - wr_req = 0
  - wr_addr = 0
  - wr_len = 0
  - wr_dat = 0 (empty FIFO head reads 0)
  - frame_done = 0
  - proto_err = 0
- **Write-to-read latency:** a pixel pushed at edge N is visible at the FIFO head and counted in fifo_count from edge N+1.
- **Request latency:** wr_req rises one edge after the IDLE condition is true. The DATA state is entered on the edge that samples wr_ack=1; the first pop is possible in the following cycle.
- **Burst gap:** at least one IDLE cycle separates consecutive bursts (last pop → IDLE → REQ).
- **Back-to-back pops:** the FIFO supports wr_dat_req held high for a full burst.

## Test plan
1. **Basic frame.** rst, then frame_sync with xres=4, yres=2, base=0x1000, stride=0x100. Push 8 pixels. Expected: requests (0x1000,4) and (0x1100,4); wr_dat matches push order; frame_done pulses once, one cycle after the 8th pop.
2. **Line split into bursts.** BURST_LEN=64, xres=150, yres=1, base=0. Expected: bursts (0x0,64), (0x100,64), (0x200,22).
3. **Backpressure.** FIFO_DEPTH=16, xres=64. Push continuously and never ack. Expected: vin_ready falls after 16 accepted pixels; no pixel is lost after acks resume; data order is preserved.
4. **Mid-burst frame_sync.** Assert frame_sync after 10 of 64 pops. Expected: next edge wr_req=0 and fifo_count=0; the new frame's first request uses the newly latched base with out_x=0.
5. **Zero resolution and protocol error.** Set xres=0: pushes are accepted and no wr_req is ever raised. Then pulse wr_dat_req in IDLE: proto_err=1 and stays 1 until rst.
6. **Address wrap.** ADDR_WIDTH=32, base=0xFFFFFF00, stride=0x100, xres=4, yres=2. Expected: the second line's request address is 0x00000000.
